// File: rtl/fetch_align_pkg.sv
// Shared constants for the fetch/realign stage: FSM encodings, halfword width
// and the opcode pattern that marks a full 32-bit instruction.
package fetch_align_pkg;

  localparam int unsigned HW_W = 16;

  localparam logic [1:0] RVC_OP_FULL = 2'b11;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_WAIT = 2'd1;
  localparam logic [1:0] F_DROP = 2'd2;

  function automatic logic is_full32(input logic [HW_W-1:0] hw);
    return hw[1:0] == RVC_OP_FULL;
  endfunction

endpackage

// File: rtl/fetch_hbuf.sv
// Three-entry halfword shift buffer: pops 0-2 halfwords from the head and
// appends 0-2 halfwords behind whatever remains, in the same cycle.
module fetch_hbuf
  import fetch_align_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [1:0]      pop_n,
  input  logic [1:0]      push_n,
  input  logic [HW_W-1:0] push_hw0,
  input  logic [HW_W-1:0] push_hw1,
  output logic [HW_W-1:0] hw0,
  output logic [HW_W-1:0] hw1,
  output logic [1:0]      count
);

  logic [HW_W-1:0] buf_q [3];
  logic [HW_W-1:0] buf_d [3];
  logic [HW_W-1:0] kept  [3];
  logic [1:0]      cnt_d;
  logic [1:0]      rem;

  always_comb begin
    rem = count - pop_n;
    for (int unsigned i = 0; i < 3; i++) kept[i] = '0;
    case (pop_n)
      2'd0: kept = buf_q;
      2'd1: begin
        kept[0] = buf_q[1];
        kept[1] = buf_q[2];
      end
      default: kept[0] = buf_q[2];
    endcase
    buf_d = kept;
    // new halfwords land directly behind the survivors of this cycle's pop
    for (int unsigned i = 0; i < 3; i++) begin
      if (push_n != 2'd0 && rem == 2'(i))
        buf_d[i] = push_hw0;
      else if (push_n == 2'd2 && (rem + 2'd1) == 2'(i))
        buf_d[i] = push_hw1;
    end
    cnt_d = rem + push_n;
    if (clear) begin
      cnt_d = '0;
      for (int unsigned i = 0; i < 3; i++) buf_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      count <= cnt_d;
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign hw0 = buf_q[0];
  assign hw1 = buf_q[1];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch/realign stage: fetches aligned words, slices them into
// halfwords and presents one RVC or 32-bit instruction per handshake.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_mem_req,
  output logic [31:0] O_mem_addr,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_data,
  output logic        O_instr_valid,
  output logic [31:0] O_instr,
  output logic [31:0] O_instr_pc,
  output logic        O_instr_compressed,
  input  logic        I_instr_ready
);

  logic [1:0]      state_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     instr_pc_q;
  logic            drop_low_q;

  logic [HW_W-1:0] hw0;
  logic [HW_W-1:0] hw1;
  logic [1:0]      count;
  logic [1:0]      pop_n;
  logic [1:0]      push_n;
  logic [1:0]      cnt_after;
  logic            full32;
  logic            consume;
  logic            ack_take;
  logic            fetch_now;

  assign full32             = is_full32(hw0);
  assign O_instr_valid      = full32 ? (count >= 2'd2) : (count != 2'd0);
  assign O_instr_compressed = O_instr_valid & ~full32;
  assign O_instr            = !O_instr_valid ? '0
                            : full32 ? {hw1, hw0} : {16'h0000, hw0};
  assign O_instr_pc         = instr_pc_q;
  assign O_mem_req          = mem_req_q;
  assign O_mem_addr         = mem_addr_q;

  assign consume   = O_instr_valid & I_instr_ready;
  assign pop_n     = !consume ? 2'd0 : (full32 ? 2'd2 : 2'd1);
  assign cnt_after = count - pop_n;
  // a redirect in the ack cycle makes the returning word stale
  assign ack_take  = (state_q == F_WAIT) && I_mem_ack && !I_redirect;
  assign push_n    = !ack_take ? 2'd0 : (drop_low_q ? 2'd1 : 2'd2);
  assign fetch_now = (state_q == F_IDLE) && !I_redirect && (cnt_after <= 2'd1);

  fetch_hbuf u_hbuf (
    .clk      (I_clk),
    .rst_n    (I_rst_n),
    .clear    (I_redirect),
    .pop_n    (pop_n),
    .push_n   (push_n),
    .push_hw0 (drop_low_q ? I_mem_data[31:16] : I_mem_data[15:0]),
    .push_hw1 (I_mem_data[31:16]),
    .hw0      (hw0),
    .hw1      (hw1),
    .count    (count)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= F_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= RESET_PC & ~32'd3;
      drop_low_q <= RESET_PC[1];
      instr_pc_q <= RESET_PC;
    end else begin
      if (I_redirect) begin
        instr_pc_q <= I_redirect_pc & ~32'd1;
        fetch_pc_q <= I_redirect_pc & ~32'd3;
        drop_low_q <= I_redirect_pc[1];
      end else begin
        if (consume) instr_pc_q <= instr_pc_q + (full32 ? 32'd4 : 32'd2);
        if (ack_take) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
          drop_low_q <= 1'b0;
        end
      end

      case (state_q)
        F_IDLE: if (fetch_now) begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= fetch_pc_q;
          state_q    <= F_WAIT;
        end
        F_WAIT: begin
          if (I_mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= F_IDLE;
          end else if (I_redirect) begin
            state_q <= F_DROP;
          end
        end
        F_DROP: if (I_mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= F_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a memory responder with programmable
// latency, directed instruction streams and an independent handshake monitor.
module tb_fetch_align;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_c;
  logic        ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mem[logic [31:0]];
  int unsigned mem_lat;
  int unsigned wait_cnt;
  logic [31:0] held_addr;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .I_clk              (clk),
    .I_rst_n            (rst_n),
    .I_redirect         (redirect),
    .I_redirect_pc      (redirect_pc),
    .O_mem_req          (mem_req),
    .O_mem_addr         (mem_addr),
    .I_mem_ack          (mem_ack),
    .I_mem_data         (mem_data),
    .O_instr_valid      (instr_valid),
    .O_instr            (instr),
    .O_instr_pc         (instr_pc),
    .O_instr_compressed (instr_c),
    .I_instr_ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0001_0001;
  endfunction

  function automatic logic [31:0] log_at(input int unsigned i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.c     = c;
    return e;
  endfunction

  // memory responder: ack after mem_lat waiting cycles, request address must hold
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    wait_cnt = 0;
    held_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem_req) begin
        if (wait_cnt == 0) held_addr = mem_addr;
        else chk("addr_hold", mem_addr, held_addr);
        if (wait_cnt >= mem_lat) begin
          mem_ack  = 1'b1;
          mem_data = rd(mem_addr);
          req_log.push_back(mem_addr);
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // handshake monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_instr: got %h at pc %h, none expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr, e.instr);
          chk("instr_pc", instr_pc, e.pc);
          chk("compressed", {31'b0, instr_c}, {31'b0, e.c});
        end
      end
    end
  end

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b0;
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
    end
  endtask

  task automatic settle(input int unsigned cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
    req_log.delete();
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_pc", instr_pc, pc & ~32'd1);
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    while (!instr_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_valid) timeout("wait_valid");
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0; mem_lat = 0;
    mem[32'h000] = 32'h00A0_0093;
    mem[32'h100] = 32'h4501_4505;
    mem[32'h104] = 32'h4509_1234;
    mem[32'h200] = 32'h0093_4505;
    mem[32'h204] = 32'h0001_00A0;
    mem[32'h300] = 32'h1111_1111;
    mem[32'h400] = 32'h0041_0113;
    mem[32'h404] = 32'h4509_4505;
    mem[32'h500] = 32'h4505_0000;

    #12;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_c", {31'b0, instr_c}, 32'd0);

    // aligned 32-bit from RESET_PC, next fetch at 4
    exp_q.push_back(mk(32'h00A0_0093, 32'h0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    drain(40);
    settle(4);
    chk("t1_req0", log_at(0), 32'h0);
    chk("t1_req1", log_at(1), 32'h4);

    // two RVC in one word
    do_redirect(32'h100);
    exp_q.push_back(mk(32'h0000_4505, 32'h100, 1'b1));
    exp_q.push_back(mk(32'h0000_4501, 32'h102, 1'b1));
    ready = 1'b1;
    drain(40);
    settle(4);

    // 32-bit instruction straddling a word boundary
    do_redirect(32'h200);
    exp_q.push_back(mk(32'h0000_4505, 32'h200, 1'b1));
    exp_q.push_back(mk(32'h00A0_0093, 32'h202, 1'b0));
    ready = 1'b1;
    drain(40);
    settle(4);

    // redirect while a slow request is outstanding
    mem_lat = 3;
    do_redirect(32'h300);
    do_redirect(32'h106);
    exp_q.push_back(mk(32'h0000_4509, 32'h106, 1'b1));
    ready = 1'b1;
    drain(80);
    chk("t4_stale", log_at(0), 32'h300);
    chk("t4_next", log_at(1), 32'h104);
    mem_lat = 0;
    settle(10);

    // decode stall with valid high
    do_redirect(32'h400);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h0041_0113);
      chk("stall_pc", instr_pc, 32'h400);
      @(posedge clk); #1;
    end
    chk("stall_reqs", 32'(req_log.size()), 32'd1);
    exp_q.push_back(mk(32'h0041_0113, 32'h400, 1'b0));
    exp_q.push_back(mk(32'h0000_4505, 32'h404, 1'b1));
    exp_q.push_back(mk(32'h0000_4509, 32'h406, 1'b1));
    ready = 1'b1;
    drain(40);
    settle(4);

    // asynchronous reset while a request is waiting
    mem_lat = 5;
    do_redirect(32'h502);
    wait_valid(40);
    begin
      int unsigned n = 0;
      while (!mem_req && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #3;
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    chk("pre_rst_instr", instr, 32'h0000_4505);
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, mem_req}, 32'd0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_pc", instr_pc, 32'h0);
    chk("async_addr", mem_addr, 32'h0);
    mem_lat = 0;
    settle(2);
    req_log.delete();
    exp_q.push_back(mk(32'h00A0_0093, 32'h0, 1'b0));
    rst_n = 1'b1;
    ready = 1'b1;
    drain(40);
    chk("t6_restart", log_at(0), 32'h0);
    settle(4);

    chk("leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
